// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt controller: state encoding, default sizes and the
// lowest-index-wins priority encoder.
package irq_pkg;

    localparam int unsigned DefNsrc = 4;
    localparam int unsigned DefIdw  = 2;

    typedef enum logic [1:0] {
        IrqIdle = 2'd0,
        IrqReq  = 2'd1,
        IrqServ = 2'd2
    } irq_state_e;

    // Index of the lowest set bit; 0 when nothing is set (callers gate on |req).
    function automatic logic [3:0] prio_enc(input logic [15:0] req);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (req[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Single-bit 2-flop synchronizer followed by a rising-edge detector (sync2 & ~sync3).
module irq_sync_edge
    import irq_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic edge_o
);

    logic sync1_q, sync2_q, sync3_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign edge_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/irq_controller.sv
// Collects NSRC request lines as pending edges, masks them and presents one interrupt at a time
// to the core with an ack/eoi handshake (no nesting).
module irq_controller
    import irq_pkg::*;
#(
    parameter int unsigned NSRC = DefNsrc,
    parameter int unsigned IDW  = DefIdw
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NSRC-1:0] src_in_i,
    input  logic            mask_wr_i,
    input  logic [NSRC-1:0] mask_din_i,
    input  logic            clr_ovr_i,
    input  logic            irq_ack_i,
    input  logic            irq_eoi_i,
    output logic            irq_o,
    output logic [IDW-1:0]  irq_id_o,
    output logic [NSRC-1:0] pending_o,
    output logic            in_service_o,
    output logic [NSRC-1:0] overrun_o
);

    localparam logic [NSRC-1:0] OneHot0 = NSRC'(1);

    irq_state_e      state_q;
    logic            irq_q;
    logic [IDW-1:0]  id_q;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] overrun_q, overrun_d;
    logic [NSRC-1:0] mask_q, mask_d;

    logic [NSRC-1:0] edge_v;
    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] id_oh;
    logic [NSRC-1:0] clr_vec;
    logic [IDW-1:0]  winner;
    logic            ack_fire;

    for (genvar i = 0; i < NSRC; i++) begin : g_sync
        irq_sync_edge u_sync (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .d_i    (src_in_i[i]),
            .edge_o (edge_v[i])
        );
    end

    always_comb begin
        mask_d   = mask_wr_i ? mask_din_i : mask_q;
        // Arbitrate against the mask as it will be after this edge, so a mask write changes
        // presentation on the very next edge.
        cand     = pending_q & ~mask_d;
        winner   = IDW'(prio_enc(16'(cand)));
        id_oh    = OneHot0 << id_q;
        ack_fire = (state_q == IrqReq) && irq_ack_i;
        clr_vec  = ack_fire ? id_oh : '0;
        // A new edge on the acked source re-pends it without counting as an overrun.
        pending_d = (pending_q & ~clr_vec) | edge_v;
        overrun_d = (clr_ovr_i ? '0 : overrun_q) | (edge_v & pending_q & ~clr_vec);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
            overrun_q <= '0;
            mask_q    <= '1;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            mask_q    <= mask_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IrqIdle;
            irq_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            unique case (state_q)
                IrqIdle: begin
                    if (|cand) begin
                        state_q <= IrqReq;
                        irq_q   <= 1'b1;
                        id_q    <= winner;
                    end
                end
                IrqReq: begin
                    if (irq_ack_i) begin
                        state_q <= IrqServ;
                        irq_q   <= 1'b0;
                    end else if (~|(cand & id_oh)) begin
                        state_q <= IrqIdle;
                        irq_q   <= 1'b0;
                    end
                end
                IrqServ: begin
                    if (irq_eoi_i) begin
                        state_q <= IrqIdle;
                    end
                end
                default: begin
                    state_q <= IrqIdle;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign irq_o        = irq_q;
    assign irq_id_o     = id_q;
    assign pending_o    = pending_q;
    assign overrun_o    = overrun_q;
    assign in_service_o = (state_q == IrqServ);

endmodule
